// File: rtl/output_neuron_backprop.sv
// Backward-pass engine for the final output neuron: computes the sigmoid delta and
// gradient-descent updates of w1, w2 and bias using one shared multiplier over six cycles.
module output_neuron_backprop #(
    parameter int unsigned W        = 16,
    parameter int unsigned LR_SHIFT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [1:0]   in1,
    input  logic [1:0]   in2,
    input  logic [W-1:0] out,
    input  logic [W-1:0] target,
    input  logic [W-1:0] w1,
    input  logic [W-1:0] w2,
    input  logic [W-1:0] bias,
    output logic [W-1:0] w1_new,
    output logic [W-1:0] w2_new,
    output logic [W-1:0] bias_new,
    output logic [W-1:0] delta,
    output logic         done_valid,
    input  logic         done_ready
);

    localparam int unsigned Frac = W - 4;
    localparam int unsigned MW   = W + 2;
    localparam int unsigned PW   = 2 * MW;

    localparam logic signed [W-1:0]  OneW   = {{(W-1){1'b0}}, 1'b1} << Frac;
    localparam logic signed [MW-1:0] OneMw  = {{(MW-1){1'b0}}, 1'b1} << Frac;
    localparam logic signed [PW-1:0] SatMax = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SatMin = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StDeriv, StDelta, StUpdW1, StUpdW2, StUpdB, StDone
    } state_e;

    state_e state_q, state_d;

    logic signed [W-1:0] out_q, target_q, w1_q, w2_q, bias_q;
    logic [1:0]          in1_q, in2_q;
    logic signed [W-1:0] deriv_q, delta_q, w1_new_q, w2_new_q, bias_new_q;

    logic                 accept;
    logic signed [W-1:0]  out_sx, out_clamp;
    logic signed [MW-1:0] err, one_minus, mul_a, mul_b;
    logic signed [PW-1:0] mul_p, prod_frac, prod_lr;

    function automatic logic signed [MW-1:0] sx_mw(input logic signed [W-1:0] v);
        return {{(MW-W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] sx_pw(input logic signed [W-1:0] v);
        return {{(PW-W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
        if (v > SatMax) begin
            return SatMax[W-1:0];
        end else if (v < SatMin) begin
            return SatMin[W-1:0];
        end
        return v[W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StDeriv;
            StDeriv: state_d = StDelta;
            StDelta: state_d = StUpdW1;
            StUpdW1: state_d = StUpdW2;
            StUpdW2: state_d = StUpdB;
            StUpdB:  state_d = StDone;
            StDone:  if (done_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state; rst_n only masks ready during reset
    always_comb begin
        start_ready = rst_n && (state_q == StIdle);
        done_valid  = (state_q == StDone);
    end

    assign accept = start_valid & start_ready;

    always_comb begin
        out_sx    = $signed(out);
        out_clamp = out_sx;
        if (out_sx[W-1]) begin
            out_clamp = '0;
        end else if (out_sx > OneW) begin
            out_clamp = OneW;
        end
    end

    assign err       = sx_mw(out_q) - sx_mw(target_q);
    assign one_minus = OneMw - sx_mw(out_q);

    // Shared multiplier operand select
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            StDeriv: begin
                mul_a = sx_mw(out_q);
                mul_b = one_minus;
            end
            StDelta: begin
                mul_a = err;
                mul_b = sx_mw(deriv_q);
            end
            StUpdW1: begin
                mul_a = sx_mw(delta_q);
                mul_b = {{(MW-2){1'b0}}, in1_q};
            end
            StUpdW2: begin
                mul_a = sx_mw(delta_q);
                mul_b = {{(MW-2){1'b0}}, in2_q};
            end
            StUpdB: begin
                mul_a = sx_mw(delta_q);
                mul_b = {{(MW-1){1'b0}}, 1'b1};
            end
            default: ;
        endcase
    end

    assign mul_p     = mul_a * mul_b;
    assign prod_frac = mul_p >>> Frac;
    assign prod_lr   = mul_p >>> LR_SHIFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q      <= '0;
            target_q   <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            bias_q     <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            deriv_q    <= '0;
            delta_q    <= '0;
            w1_new_q   <= '0;
            w2_new_q   <= '0;
            bias_new_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        out_q    <= out_clamp;
                        target_q <= $signed(target);
                        w1_q     <= $signed(w1);
                        w2_q     <= $signed(w2);
                        bias_q   <= $signed(bias);
                        in1_q    <= in1;
                        in2_q    <= in2;
                    end
                end
                // deriv never exceeds 1.0/4, so truncation to W bits is exact
                StDeriv: deriv_q    <= prod_frac[W-1:0];
                StDelta: delta_q    <= sat_w(prod_frac);
                StUpdW1: w1_new_q   <= sat_w(sx_pw(w1_q) - prod_lr);
                StUpdW2: w2_new_q   <= sat_w(sx_pw(w2_q) - prod_lr);
                StUpdB:  bias_new_q <= sat_w(sx_pw(bias_q) - prod_lr);
                default: ;
            endcase
        end
    end

    assign delta    = delta_q;
    assign w1_new   = w1_new_q;
    assign w2_new   = w2_new_q;
    assign bias_new = bias_new_q;

endmodule

// File: tb/tb_output_neuron_backprop.sv
// Self-checking bench for output_neuron_backprop: scoreboard of expected parameter
// updates pushed at accept and compared when done_valid rises.
module tb_output_neuron_backprop;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  in1, in2;
    logic [15:0] out, target, w1, w2, bias;
    logic [15:0] w1_new, w2_new, bias_new, delta;
    logic        done_valid;
    logic        done_ready;

    typedef struct {
        int d;
        int w1;
        int w2;
        int b;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    output_neuron_backprop #(
        .W        (16),
        .LR_SHIFT (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .in1         (in1),
        .in2         (in2),
        .out         (out),
        .target      (target),
        .w1          (w1),
        .w2          (w2),
        .bias        (bias),
        .w1_new      (w1_new),
        .w2_new      (w2_new),
        .bias_new    (bias_new),
        .delta       (delta),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input int a1, input int a2, input int b);
        exp_t e;
        e.d  = d;
        e.w1 = a1;
        e.w2 = a2;
        e.b  = b;
        return e;
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic exp_t model(input int i1, input int i2, input int o, input int t,
                                   input int a1, input int a2, input int b);
        int oc, dv, dl;
        oc = (o < 0) ? 0 : ((o > 4096) ? 4096 : o);
        dv = (oc * (4096 - oc)) >>> 12;
        dl = sat16(((oc - t) * dv) >>> 12);
        return mk(dl, sat16(a1 - ((dl * i1) >>> 3)), sat16(a2 - ((dl * i2) >>> 3)),
                  sat16(b - (dl >>> 3)));
    endfunction

    task automatic drive(input int i1, input int i2, input int o, input int t,
                         input int a1, input int a2, input int b);
        in1    = i1[1:0];
        in2    = i2[1:0];
        out    = o[15:0];
        target = t[15:0];
        w1     = a1[15:0];
        w2     = a2[15:0];
        bias   = b[15:0];
    endtask

    task automatic scramble();
        drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom),
              int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    // Called #1 after an edge; returns #1 after the edge that hands back the result.
    task automatic run_txn(input int i1, input int i2, input int o, input int t,
                           input int a1, input int a2, input int b, input exp_t e,
                           input int hold);
        logic signed [31:0] pd, pw1, s_d, s_w1, s_w2, s_b;
        int   lat;
        bit   got;
        exp_t x;
        pd  = $signed(delta);
        pw1 = $signed(w1_new);
        check("sready", start_ready, 1);
        drive(i1, i2, o, t, a1, a2, b);
        start_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        scramble();
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("dhold", $signed(delta), pd);
            if (k == 2) check("w1hold", $signed(w1_new), pw1);
            if (done_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("latency", lat, 5);
        s_d  = $signed(delta);
        s_w1 = $signed(w1_new);
        s_w2 = $signed(w2_new);
        s_b  = $signed(bias_new);
        for (int k = 0; k < hold; k++) begin
            if (k == 3) begin
                drive(1, 1, 2048, 4096, 0, 0, 0);
                start_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            check("bp_valid", done_valid, 1);
            check("bp_sready", start_ready, 0);
            check("bp_delta", $signed(delta), s_d);
            check("bp_w1", $signed(w1_new), s_w1);
            check("bp_w2", $signed(w2_new), s_w2);
            check("bp_bias", $signed(bias_new), s_b);
        end
        x = sb_q.pop_front();
        check("delta", $signed(delta), x.d);
        check("w1_new", $signed(w1_new), x.w1);
        check("w2_new", $signed(w2_new), x.w2);
        check("bias_new", $signed(bias_new), x.b);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        check("idle_dv", done_valid, 0);
        check("idle_sr", start_ready, 1);
    endtask

    initial begin
        int seen;
        int ri1, ri2, ro, rt, ra1, ra2, rb;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sready", start_ready, 0);
        check("rst_dv", done_valid, 0);
        check("rst_delta", $signed(delta), 0);
        check("rst_w1", $signed(w1_new), 0);
        check("rst_w2", $signed(w2_new), 0);
        check("rst_bias", $signed(bias_new), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(1, 2, 2048, 4096, 4096, 0, 0, mk(-512, 4160, 128, 64), 0);
        run_txn(1, 2, 2048, 2048, 100, -100, 7, mk(0, 100, -100, 7), 0);
        run_txn(3, 3, 5000, 0, 100, -100, 7, mk(0, 100, -100, 7), 0);
        run_txn(3, 0, 2048, 4096, 32767, 0, 0, mk(-512, 32767, 0, 64), 0);
        run_txn(1, 3, 3072, 0, 0, -32768, 0, mk(576, -72, -32768, -72), 10);

        // Abort an update in UPD_W1 with a one-edge reset
        drive(1, 2, 2048, 4096, 4096, 0, 0);
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_delta", $signed(delta), -512);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_sready", start_ready, 0);
        check("mid_rst_dv", done_valid, 0);
        check("mid_rst_delta", $signed(delta), 0);
        check("mid_rst_w1", $signed(w1_new), 0);
        check("mid_rst_w2", $signed(w2_new), 0);
        check("mid_rst_bias", $signed(bias_new), 0);
        rst_n = 1'b1;
        seen  = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done_valid) seen++;
        end
        check("aborted_done", seen, 0);
        run_txn(1, 2, 2048, 4096, 4096, 0, 0, mk(-512, 4160, 128, 64), 0);

        for (int n = 0; n < 6; n++) begin
            ri1 = int'($urandom_range(0, 3));
            ri2 = int'($urandom_range(0, 3));
            ro  = int'($urandom_range(0, 8191)) - 2048;
            rt  = int'($urandom_range(0, 65535)) - 32768;
            if (n < 3) rt = int'($urandom_range(0, 4096));
            ra1 = int'($urandom_range(0, 65535)) - 32768;
            ra2 = int'($urandom_range(0, 65535)) - 32768;
            rb  = int'($urandom_range(0, 65535)) - 32768;
            run_txn(ri1, ri2, ro, rt, ra1, ra2, rb, model(ri1, ri2, ro, rt, ra1, ra2, rb),
                    n % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/output_neuron_backprop.md
# output_neuron_backprop

Backward-pass engine for the network's final output neuron. It takes the sigmoid output produced by the forward path, together with the training target, the neuron's inputs and its current weights and bias. It computes the output delta and produces updated `w1`, `w2` and `bias` by gradient descent. A start/done valid-ready handshake brackets each update, and a single shared multiplier runs a multi-cycle FSM. The block sits between the output neuron/activation stage and the parameter registers that feed the next forward pass.

## Interface
- `W`, 16: width of every fixed-point value. Format is signed Q4.12, so 4096 = 1.0.
- `LR_SHIFT`, 3: the learning rate is 2^-LR_SHIFT.

- `clk`  in  1  single clock. All logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start_valid`  in  1  input bundle valid.
- `start_ready`  out  1  high only in IDLE with `rst_n` high.
- `in1`, `in2`  in  2  unsigned integer neuron inputs.
- `out`  in  W  forward sigmoid output (Q4.12).
- `target`  in  W  training target (Q4.12).
- `w1`, `w2`, `bias`  in  W  current signed parameters (Q4.12).
- `w1_new`, `w2_new`, `bias_new`  out  W  updated parameters.
- `delta`  out  W  output-neuron delta, saturated.
- `done_valid`  out  1  result bundle valid.
- `done_ready`  in  1  consumer accepts the result.

## Operation
- **States:** IDLE → DERIV → DELTA → UPD_W1 → UPD_W2 → UPD_B → DONE → IDLE.
- **Accept:** `start_valid & start_ready` at an edge registers all inputs, and the FSM goes to DERIV.
  - Input changes after acceptance are ignored.
- **Input clamp:** `out` is clamped to [0, 4096] at capture. `target` is used unclamped.
- **Arithmetic:** every `>>>` is arithmetic, i.e. truncation toward −inf.
  - err = out − target, kept in W+1 bits.
  - one_minus = 4096 − out.
  - deriv = (out × one_minus) >>> 12.
  - delta = sat_W((err × deriv) >>> 12).
  - step_wi = (delta × in_i) >>> LR_SHIFT.
  - step_b = delta >>> LR_SHIFT.
  - new = sat_W(param − step), computed at full width before saturation.
- **Saturation range:** [−32768, 32767].
- **Shared multiplier:** one multiplier per cycle. DERIV and DELTA each use it once. The UPD_* states each use a 2-bit × W multiply or pass-through.
- **DONE:** `done_valid` = 1, and all result outputs hold stable until `done_ready` is sampled high.
  - At that edge the FSM goes to IDLE.
  - `done_ready` outside DONE is ignored.
- **Busy:** `start_valid` while not in IDLE is ignored (`start_ready` = 0). No queuing.
- **Reset:** `rst_n` low at an edge forces IDLE regardless of state.
  - All result registers and `done_valid` clear to 0.
  - `start_ready` is 0 while `rst_n` is low.
  - An in-flight update is discarded and never reported.

## Timing
- **Reset values:** `w1_new` = `w2_new` = `bias_new` = `delta` = 0, `done_valid` = 0, `start_ready` = 0 during reset and 1 in the first cycle after release.
- **Latency:** call the accept edge E0.
  - E1: deriv is registered.
  - E2: delta is registered.
  - E3: `w1_new` is registered.
  - E4: `w2_new` is registered.
  - E5: `bias_new` is registered and the FSM enters DONE.
  - `done_valid` is high from E5 onward, i.e. 5 cycles after acceptance.
- **Output timing:** `delta` and each `*_new` update only at their own edge, and all are stable while `done_valid` is high.
- **Throughput:** a result taken at edge Ed gives `start_ready` = 1 after Ed. The next accept is possible at Ed+1, so the minimum period is 7 cycles with `done_ready` tied high.
- **Registering:** `start_ready` and `done_valid` are decoded from registered state only. No combinational input-to-output paths.

## Test plan
- **Nominal update:** `out`=2048, `target`=4096, `in1`=1, `in2`=2, `w1`=4096, `w2`=0, `bias`=0, `LR_SHIFT`=3 → `delta`=−512, `w1_new`=4160, `w2_new`=128, `bias_new`=64. `done_valid` rises exactly 5 cycles after accept.
- **Zero error:** `out`=`target`=2048, `w1`=100, `w2`=−100, `bias`=7 → `delta`=0 and outputs equal inputs. Then `out`=5000 (clamped to 4096), `target`=0 → deriv = 0, `delta`=0, parameters unchanged.
- **Saturation:**
  - `w1`=32767, `in1`=3, `out`=2048, `target`=4096 → `w1_new`=32767.
  - `out`=3072, `target`=0, `w2`=−32768, `in2`=3 → `delta`=576, `w2_new`=−32768.
- **Backpressure:** hold `done_ready` low for 10 cycles after `done_valid` rises → outputs stable, `start_ready` = 0, and a pulse on `start_valid` is ignored. Raise `done_ready` → IDLE next cycle, and back-to-back accept at Ed+1 works.
- **Reset mid-operation:** drop `rst_n` for one edge while in UPD_W1 → next cycle all outputs are 0 and `done_valid` = 0 with no result reported. `start_ready` = 1 after release, and a fresh nominal run reproduces the nominal-update results.
